// File: rtl/prog_loader.sv
// prog_loader
// Writer side of the program memory. Accepts a program image as a byte
// stream (valid/ready), packs big-endian 16-bit instruction words, writes
// them sequentially from address 0, verifies an 8-bit additive checksum and
// keeps the CPU held in reset until the image has loaded cleanly.
//
// Frame: LEN_HI, LEN_LO (word count N), N x (DATA_HI, DATA_LO), CSUM.
//
// Ports:
//   clk           system clock
//   rst           synchronous, active-high reset
//   in_data       incoming byte
//   in_valid      in_data is valid
//   in_ready      loader can accept a byte
//   mem_we        program memory write enable, one-cycle pulse per word
//   mem_addr      write address
//   mem_wdata     write data {high byte, low byte}
//   cpu_hold      held high until the image has loaded with a good checksum
//   done          sticky: image loaded and checksum OK
//   err           sticky: length overflow or checksum mismatch
//   words_loaded  count of words written
module prog_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        ST_LEN_HI  = 3'd0,
        ST_LEN_LO  = 3'd1,
        ST_DATA_HI = 3'd2,
        ST_DATA_LO = 3'd3,
        ST_CSUM    = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERR     = 3'd6
    } state_t;

    // Largest legal word count; 17 bits so 2**16 would still be representable.
    localparam logic [16:0]       MAX_WORDS = 17'd1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   WL_ONE    = {{ADDR_W{1'b0}}, 1'b1};

    // Running checksum: byte-wise sum modulo 256.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        csum_add = acc + b;
    endfunction

    state_t            state_r;
    state_t            state_next_s;
    logic              in_ready_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [15:0]       mem_wdata_r;
    logic              cpu_hold_r;
    logic              done_r;
    logic              err_r;
    logic [ADDR_W:0]   words_loaded_r;
    logic [15:0]       length_r;
    logic [7:0]        csum_r;
    logic [7:0]        hi_r;
    logic [16:0]       rx_cnt_r;      // words received so far in this frame

    logic              accept_s;
    logic [16:0]       len_full_s;
    logic              last_word_s;

    assign accept_s    = in_valid && in_ready_r;
    // Full length as it will be once the LEN_LO byte is taken this cycle.
    assign len_full_s  = {1'b0, length_r[15:8], in_data};
    assign last_word_s = ((rx_cnt_r + 17'd1) == {1'b0, length_r});

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_LEN_HI;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; only an accepted byte moves the frame forward.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_LEN_HI: begin
                if (accept_s) state_next_s = ST_LEN_LO;
                else          state_next_s = ST_LEN_HI;
            end
            ST_LEN_LO: begin
                if (accept_s) begin
                    if (len_full_s > MAX_WORDS)   state_next_s = ST_ERR;
                    else if (len_full_s == 17'd0) state_next_s = ST_CSUM;
                    else                          state_next_s = ST_DATA_HI;
                end else begin
                    state_next_s = ST_LEN_LO;
                end
            end
            ST_DATA_HI: begin
                if (accept_s) state_next_s = ST_DATA_LO;
                else          state_next_s = ST_DATA_HI;
            end
            ST_DATA_LO: begin
                if (accept_s) begin
                    if (last_word_s) state_next_s = ST_CSUM;
                    else             state_next_s = ST_DATA_HI;
                end else begin
                    state_next_s = ST_DATA_LO;
                end
            end
            ST_CSUM: begin
                if (accept_s) begin
                    if (in_data == csum_r) state_next_s = ST_DONE;
                    else                   state_next_s = ST_ERR;
                end else begin
                    state_next_s = ST_CSUM;
                end
            end
            ST_DONE: state_next_s = ST_DONE;
            ST_ERR:  state_next_s = ST_ERR;
            default: state_next_s = ST_ERR;
        endcase
    end

    // Status outputs are registered from the next state so they change in
    // the cycle right after the terminating byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_r <= 1'b1;
            cpu_hold_r <= 1'b1;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            in_ready_r <= (state_next_s != ST_DONE) && (state_next_s != ST_ERR);
            cpu_hold_r <= (state_next_s != ST_DONE);
            done_r     <= (state_next_s == ST_DONE);
            err_r      <= (state_next_s == ST_ERR);
        end
    end

    // Datapath: length capture, word assembly, checksum and memory writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we_r       <= 1'b0;
            mem_addr_r     <= '0;
            mem_wdata_r    <= 16'h0000;
            words_loaded_r <= '0;
            length_r       <= 16'h0000;
            csum_r         <= 8'h00;
            hi_r           <= 8'h00;
            rx_cnt_r       <= 17'd0;
        end else begin
            // The write pulse follows the DATA_LO accept by exactly one cycle.
            mem_we_r <= accept_s && (state_r == ST_DATA_LO);

            // Address and count advance on the edge that ends the pulse.
            if (mem_we_r) begin
                mem_addr_r     <= mem_addr_r + ADDR_ONE;
                words_loaded_r <= words_loaded_r + WL_ONE;
            end

            if (accept_s) begin
                case (state_r)
                    ST_LEN_HI:  length_r[15:8] <= in_data;
                    ST_LEN_LO:  length_r[7:0]  <= in_data;
                    ST_DATA_HI: begin
                        hi_r   <= in_data;
                        csum_r <= csum_add(csum_r, in_data);
                    end
                    ST_DATA_LO: begin
                        mem_wdata_r <= {hi_r, in_data};
                        csum_r      <= csum_add(csum_r, in_data);
                        rx_cnt_r    <= rx_cnt_r + 17'd1;
                    end
                    default: begin
                        csum_r <= csum_r;
                    end
                endcase
            end
        end
    end

    assign in_ready     = in_ready_r;
    assign mem_we       = mem_we_r;
    assign mem_addr     = mem_addr_r;
    assign mem_wdata    = mem_wdata_r;
    assign cpu_hold     = cpu_hold_r;
    assign done         = done_r;
    assign err          = err_r;
    assign words_loaded = words_loaded_r;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [8:0]  words_loaded;

    prog_loader #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .done(done), .err(err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] frame;   // byte i at [63-8*i -: 8]
        int          nbytes;
        logic        exp_done;
        logic        exp_err;
        int          exp_wl;
        int          exp_acc;
        int          exp_nwr;
        logic [7:0]  a0;
        logic [15:0] d0;
        logic [7:0]  a1;
        logic [15:0] d1;
    } vec_t;

    vec_t        vecs[6];
    int          pass_cnt = 0;
    int          tot_cnt  = 0;
    int          acc_cnt  = 0;
    logic [7:0]  wr_addr[$];
    logic [15:0] wr_data[$];
    logic        both_seen = 1'b0;

    // Write and invariant monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
        end
        if (done && err) both_seen = 1'b1;
    end

    function automatic vec_t mk(input logic [63:0] f, input int n, input logic ed, input logic ee,
                                input int wl, input int acc, input int nwr,
                                input logic [7:0] a0, input logic [15:0] d0,
                                input logic [7:0] a1, input logic [15:0] d1);
        vec_t v;
        v.frame = f; v.nbytes = n; v.exp_done = ed; v.exp_err = ee; v.exp_wl = wl;
        v.exp_acc = acc; v.exp_nwr = nwr; v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp_v);
        tot_cnt++;
        if (act == exp_v) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
    endtask

    // Present a byte and wait (bounded) until it is accepted.
    task automatic send_byte(input logic [7:0] b);
        bit got;
        got = 1'b0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        for (int k = 0; k < 6 && !got; k++) begin
            if (in_ready) begin
                got = 1'b1;
                acc_cnt++;
                @(posedge clk);
            end else begin
                @(posedge clk);
                @(negedge clk);
            end
        end
    endtask

    task automatic go_idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        acc_cnt   = 0;
        both_seen = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        clear_log();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_rst_in_ready"}, int'(in_ready), 1);
        chk({tag, "_rst_mem_we"}, int'(mem_we), 0);
        chk({tag, "_rst_mem_addr"}, int'(mem_addr), 0);
        chk({tag, "_rst_mem_wdata"}, int'(mem_wdata), 0);
        chk({tag, "_rst_cpu_hold"}, int'(cpu_hold), 1);
        chk({tag, "_rst_done"}, int'(done), 0);
        chk({tag, "_rst_err"}, int'(err), 0);
        chk({tag, "_rst_words"}, int'(words_loaded), 0);
    endtask

    task automatic check_final(input string tag, input vec_t v);
        chk({tag, "_done"}, int'(done), int'(v.exp_done));
        chk({tag, "_err"}, int'(err), int'(v.exp_err));
        chk({tag, "_cpu_hold"}, int'(cpu_hold), int'(!v.exp_done));
        chk({tag, "_in_ready"}, int'(in_ready), 0);
        chk({tag, "_words"}, int'(words_loaded), v.exp_wl);
        chk({tag, "_accepted"}, acc_cnt, v.exp_acc);
        chk({tag, "_nwrites"}, wr_addr.size(), v.exp_nwr);
        chk({tag, "_done_err_excl"}, int'(both_seen), 0);
        if (v.exp_nwr >= 1 && wr_addr.size() >= 1) begin
            chk({tag, "_w0_addr"}, int'(wr_addr[0]), int'(v.a0));
            chk({tag, "_w0_data"}, int'(wr_data[0]), int'(v.d0));
        end
        if (v.exp_nwr >= 2 && wr_addr.size() >= 2) begin
            chk({tag, "_w1_addr"}, int'(wr_addr[1]), int'(v.a1));
            chk({tag, "_w1_data"}, int'(wr_data[1]), int'(v.d1));
        end
    endtask

    initial begin
        vec_t        v;
        logic [7:0]  b;
        logic [7:0]  cs;
        logic [15:0] w;
        int          bad;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // csum of 12 34 AB CD = 0x1BE -> BE; FF+01 = 0x100 -> 00
        vecs[0] = mk(64'h0002_1234_ABCD_BE00, 7, 1'b1, 1'b0, 2, 7, 2, 8'h00, 16'h1234, 8'h01, 16'hABCD);
        vecs[1] = mk(64'h0002_1234_ABCD_0000, 7, 1'b0, 1'b1, 2, 7, 2, 8'h00, 16'h1234, 8'h01, 16'hABCD);
        vecs[2] = mk(64'h0000_0000_0000_0000, 3, 1'b1, 1'b0, 0, 3, 0, 8'h00, 16'h0000, 8'h00, 16'h0000);
        vecs[3] = mk(64'h0000_0100_0000_0000, 3, 1'b0, 1'b1, 0, 3, 0, 8'h00, 16'h0000, 8'h00, 16'h0000);
        vecs[4] = mk(64'h0101_5566_0000_0000, 4, 1'b0, 1'b1, 0, 2, 0, 8'h00, 16'h0000, 8'h00, 16'h0000);
        vecs[5] = mk(64'h0001_FF01_0000_0000, 5, 1'b1, 1'b0, 1, 5, 1, 8'h00, 16'hFF01, 8'h00, 16'h0000);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset("init");

        // Table: full-rate frames
        for (int i = 0; i < 6; i++) begin
            do_reset();
            for (int j = 0; j < vecs[i].nbytes; j++) send_byte(vecs[i].frame[63 - 8*j -: 8]);
            go_idle();
            repeat (3) @(negedge clk);
            check_final($sformatf("vec%0d", i), vecs[i]);
        end

        // Nominal frame with random gaps on in_valid
        do_reset();
        for (int j = 0; j < vecs[0].nbytes; j++) begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_data  = 8'hEE;
            end
            send_byte(vecs[0].frame[63 - 8*j -: 8]);
        end
        go_idle();
        repeat (3) @(negedge clk);
        check_final("gaps", vecs[0]);

        // Reset mid-load, next byte held valid during the reset cycle
        do_reset();
        send_byte(8'h00); send_byte(8'h02); send_byte(8'h12);
        send_byte(8'h34); send_byte(8'hAB);
        @(negedge clk);
        rst      = 1'b1;
        in_data  = 8'hCD;
        in_valid = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        check_reset("midrst");
        repeat (3) @(negedge clk);
        chk("midrst_nwrites", wr_addr.size(), 1);
        chk("midrst_state_idle", int'(in_ready), 1);
        clear_log();
        for (int j = 0; j < vecs[0].nbytes; j++) send_byte(vecs[0].frame[63 - 8*j -: 8]);
        go_idle();
        repeat (3) @(negedge clk);
        check_final("reload", vecs[0]);

        // Maximum image: 256 words, word i = {i, ~i}
        do_reset();
        send_byte(8'h01);
        send_byte(8'h00);
        cs = 8'h00;
        for (int i = 0; i < 256; i++) begin
            b = i[7:0];
            w = {b, ~b};
            send_byte(w[15:8]);
            send_byte(w[7:0]);
            cs = cs + w[15:8] + w[7:0];
        end
        send_byte(cs);
        go_idle();
        repeat (3) @(negedge clk);
        v = mk(64'h0, 0, 1'b1, 1'b0, 256, 515, 256, 8'h00, 16'h00FF, 8'h01, 16'h01FE);
        check_final("max", v);
        bad = 0;
        for (int i = 0; i < wr_addr.size(); i++) begin
            b = i[7:0];
            if (wr_addr[i] != b || wr_data[i] != {b, ~b}) bad++;
        end
        chk("max_all_writes_bad", bad, 0);
        if (wr_addr.size() == 256) begin
            chk("max_last_addr", int'(wr_addr[255]), 8'hFF);
            chk("max_last_data", int'(wr_data[255]), 16'hFF00);
        end else begin
            chk("max_write_count", wr_addr.size(), 256);
        end

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Writer side of the program memory. It receives a program image as a byte stream over a valid/ready handshake, assembles big-endian 16-bit instruction words, and writes them sequentially into program memory starting at address 0. It verifies an 8-bit checksum and holds the CPU (PC register) in reset until the image loads cleanly. It sits between the host link and the program memory write port that the PC fetch path reads from.

Parameters:
ADDR_W, 8, program memory address width; maximum image size is 2**ADDR_W words.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
in_data  in  8  incoming byte
in_valid  in  1  in_data is valid
in_ready  out  1  loader can accept a byte
mem_we  out  1  program memory write enable, one-cycle pulse per word
mem_addr  out  ADDR_W  write address
mem_wdata  out  16  write data, {high byte, low byte}
cpu_hold  out  1  drives PC/CPU reset; 1 until load completes
done  out  1  sticky, image loaded and checksum OK
err  out  1  sticky, length overflow or checksum mismatch
words_loaded  out  ADDR_W+1  count of words written

Behaviour:
- Reset is synchronous and active-high on clk. It may occur at any time, including mid-load. Reset values: state=LEN_HI, in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, err=0, words_loaded=0, length=0, csum=0.
- Byte transfer occurs on any rising edge with in_valid && in_ready. in_data is ignored otherwise. in_valid may drop between bytes with no effect.
- Frame format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then N x (DATA_HI, DATA_LO), then CSUM.
- State machine:
  - LEN_HI: on accept, length[15:8]=in_data, go to LEN_LO.
  - LEN_LO: on accept, length[7:0]=in_data.
    - If the full length > 2**ADDR_W, go to ERR.
    - Else if the full length == 0, go to CSUM.
    - Else go to DATA_HI.
  - DATA_HI: on accept, latch hi byte, csum += in_data (mod 256), go to DATA_LO.
  - DATA_LO: on accept, csum += in_data, then go to DATA_HI, or to CSUM if this is word N.
    - The next cycle: mem_we=1, mem_wdata={hi,in_data}, mem_addr=current word index.
    - The cycle after the pulse: mem_addr increments and words_loaded increments.
  - CSUM: on accept, go to DONE if in_data == csum, else ERR. Length bytes are not included in csum.
  - DONE: in_ready=0, done=1, cpu_hold=0. Sticky until rst.
  - ERR: in_ready=0, err=1, cpu_hold=1. Sticky until rst. No further writes.
- in_ready is 1 in LEN_HI through CSUM and 0 in DONE/ERR. It falls the cycle after the terminating byte.
- Write latency: mem_we asserts exactly 1 cycle after the DATA_LO accept. mem_we is never asserted in any other state or for DATA_HI.
- Back-to-back bytes at full rate (in_valid held high) are accepted every cycle with no stalls.
- At the N == 2**ADDR_W boundary, the last write goes to address 2**ADDR_W-1. mem_addr wrapping to 0 afterwards is permitted. words_loaded ends at 2**ADDR_W and does not wrap.
- Reset mid-load: abort immediately, no mem_we on the reset cycle or after it. Memory contents already written are left untouched. A reloaded image overwrites them from address 0.
- done and err are never both 1.

Test Plan:
- Nominal load, stream 00 02 12 34 AB CD BE -> mem_we pulses with (addr 0, 0x1234) and (addr 1, 0xABCD). Then done=1, cpu_hold=0, words_loaded=2, in_ready=0, err=0.
- Bad checksum, same frame with last byte 00 -> err=1, cpu_hold=1, done=0, both writes still performed, in_ready=0.
- Empty image, stream 00 00 00 -> no mem_we, done=1, words_loaded=0. With last byte 01 instead, err=1.
- Length overflow (ADDR_W=8), stream 01 01 -> err=1 after LEN_LO, no writes, and further in_valid bytes are not accepted. Length 01 00 (256 words) is legal and last write goes to addr 0xFF.
- Backpressure/gaps: nominal frame with in_valid toggling 1-0-0-1 pseudo-randomly -> identical writes and final state; mem_we count == 2.
- Reset mid-load: after 00 02 12 34 AB, assert rst 1 cycle -> no further mem_we, all outputs at reset values. A full nominal frame afterwards loads correctly from addr 0 with done=1.
